// File: rtl/barrido_tabla_verdad_pkg.sv
// -----------------------------------------------------------------------------
// barrido_pkg
// Shared definitions for the truth-table sweep stage.
// Contents:
//   estado_e     - sweep FSM state encoding
//   NUM_VEC      - number of input vectors of a 3-input function
//   IDX_W        - width of the vector index
//   primer_bit() - index of the lowest set bit; 0 when no bit is set
// -----------------------------------------------------------------------------
package barrido_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRIVE  = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } estado_e;

  localparam int unsigned NUM_VEC = 8;
  localparam int unsigned IDX_W   = 3;

  // Priority encoder: scanning downwards leaves the lowest set bit as result.
  function automatic logic [IDX_W-1:0] primer_bit(input logic [NUM_VEC-1:0] v);
    logic [IDX_W-1:0] r;
    r = {IDX_W{1'b0}};
    for (int i = NUM_VEC - 1; i >= 0; i--) begin
      if (v[i]) begin
        r = IDX_W'(i);
      end else begin
        r = r;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/barrido_tabla_verdad_if.sv
// -----------------------------------------------------------------------------
// barrido_tabla_verdad_if
// Bundle between the sweep stage and its environment.
//   master (sweep stage): takes start, F; drives A, B, C, busy, done,
//                         tabla, match, fail_idx
//   slave  (environment): the mirror image
// -----------------------------------------------------------------------------
interface barrido_tabla_verdad_if;
  import barrido_pkg::*;

  logic               start;
  logic               A;
  logic               B;
  logic               C;
  logic               F;
  logic               busy;
  logic               done;
  logic [NUM_VEC-1:0] tabla;
  logic               match;
  logic [IDX_W-1:0]   fail_idx;

  modport master (
    input  start, F,
    output A, B, C, busy, done, tabla, match, fail_idx
  );

  modport slave (
    output start, F,
    input  A, B, C, busy, done, tabla, match, fail_idx
  );

endinterface

// File: rtl/barrido_tabla_verdad_contador_asentamiento.sv
// -----------------------------------------------------------------------------
// contador_asentamiento
// 4-bit settle down-counter.
// Ports:
//   clk, rst       - clock, synchronous active-high reset
//   clr_i          - force the count to 0
//   load_i         - load carga_i (takes priority over counting)
//   carga_i[3:0]   - value loaded on load_i
//   en_i           - decrement while non-zero
//   cuenta_cero_o  - count is 0
// -----------------------------------------------------------------------------
module contador_asentamiento (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr_i,
  input  logic       load_i,
  input  logic [3:0] carga_i,
  input  logic       en_i,
  output logic       cuenta_cero_o
);

  logic [3:0] cnt_q;

  // Count register: clear, load, then saturating decrement.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= 4'd0;
    end else if (clr_i) begin
      cnt_q <= 4'd0;
    end else if (load_i) begin
      cnt_q <= carga_i;
    end else if (en_i && (cnt_q != 4'd0)) begin
      cnt_q <= cnt_q - 4'd1;
    end else begin
      cnt_q <= cnt_q;
    end
  end

  assign cuenta_cero_o = (cnt_q == 4'd0);

endmodule

// File: rtl/barrido_tabla_verdad.sv
// -----------------------------------------------------------------------------
// barrido_tabla_verdad
// Sweeps {A,B,C} through 0..7, holds each vector SETTLE cycles, samples F in
// one extra cycle and builds the observed truth table, then compares it with
// EXPECTED.
// Parameters: SETTLE (1..15) settle cycles per vector, EXPECTED reference table.
// Ports:
//   clk, rst - clock, synchronous active-high reset
//   bus      - master side of barrido_tabla_verdad_if (start, A/B/C, F, busy,
//              done, tabla, match, fail_idx)
// -----------------------------------------------------------------------------
module barrido_tabla_verdad
  import barrido_pkg::*;
#(
  parameter int unsigned        SETTLE   = 2,
  parameter logic [NUM_VEC-1:0] EXPECTED = 8'h00
) (
  input logic                     clk,
  input logic                     rst,
  barrido_tabla_verdad_if.master  bus
);

  localparam logic [3:0]       CARGA    = 4'(SETTLE - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_VEC - 1);
  localparam logic [IDX_W-1:0] IDX_UNO  = IDX_W'(1);

  estado_e            state_q;
  logic [IDX_W-1:0]   idx_q;
  logic               a_q;
  logic               b_q;
  logic               c_q;
  logic               busy_q;
  logic               done_q;
  logic [NUM_VEC-1:0] tabla_q;

  logic               cnt_clr;
  logic               cnt_load;
  logic               cnt_en;
  logic               cuenta_cero;
  logic [NUM_VEC-1:0] diff;

  // Counter control: reload on every entry into DRIVE, count only in DRIVE.
  always_comb begin
    cnt_clr  = 1'b0;
    cnt_load = 1'b0;
    cnt_en   = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_load = bus.start;
        cnt_clr  = ~bus.start;
      end
      DRIVE: begin
        cnt_en = 1'b1;
      end
      SAMPLE: begin
        cnt_load = (idx_q != IDX_LAST);
      end
      DONE: begin
        cnt_load = bus.start;
      end
      default: begin
        cnt_clr = 1'b1;
      end
    endcase
  end

  contador_asentamiento u_contador (
    .clk           (clk),
    .rst           (rst),
    .clr_i         (cnt_clr),
    .load_i        (cnt_load),
    .carga_i       (CARGA),
    .en_i          (cnt_en),
    .cuenta_cero_o (cuenta_cero)
  );

  // Sweep FSM with registered stimulus, status and captured table.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= {IDX_W{1'b0}};
      a_q     <= 1'b0;
      b_q     <= 1'b0;
      c_q     <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      tabla_q <= {NUM_VEC{1'b0}};
    end else begin
      case (state_q)
        IDLE: begin
          idx_q         <= {IDX_W{1'b0}};
          tabla_q       <= {NUM_VEC{1'b0}};
          {a_q,b_q,c_q} <= {IDX_W{1'b0}};
          done_q        <= 1'b0;
          if (bus.start) begin
            state_q <= DRIVE;
            busy_q  <= 1'b1;
          end else begin
            busy_q  <= 1'b0;
          end
        end
        DRIVE: begin
          {a_q,b_q,c_q} <= idx_q;
          if (cuenta_cero) begin
            state_q <= SAMPLE;
          end
        end
        SAMPLE: begin
          tabla_q[idx_q] <= bus.F;
          if (idx_q == IDX_LAST) begin
            state_q       <= DONE;
            busy_q        <= 1'b0;
            done_q        <= 1'b1;
            {a_q,b_q,c_q} <= {IDX_W{1'b0}};
          end else begin
            // Next vector is presented on the same edge that enters DRIVE.
            state_q       <= DRIVE;
            idx_q         <= idx_q + IDX_UNO;
            {a_q,b_q,c_q} <= idx_q + IDX_UNO;
          end
        end
        DONE: begin
          {a_q,b_q,c_q} <= {IDX_W{1'b0}};
          if (bus.start) begin
            state_q <= DRIVE;
            idx_q   <= {IDX_W{1'b0}};
            tabla_q <= {NUM_VEC{1'b0}};
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign diff = tabla_q ^ EXPECTED;

  assign bus.A        = a_q;
  assign bus.B        = b_q;
  assign bus.C        = c_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.tabla    = tabla_q;
  assign bus.match    = (diff == {NUM_VEC{1'b0}});
  assign bus.fail_idx = primer_bit(diff);

endmodule

// File: tb/tb_barrido_tabla_verdad.sv
// -----------------------------------------------------------------------------
// tb_barrido_tabla_verdad
// Two sweep stages share clock, reset and start: dut0 (SETTLE=2,
// EXPECTED=80) probes a selectable function (AND, A|B, random table); dut1
// (SETTLE=1, EXPECTED=96) probes 3-input parity registered one cycle late.
// Cycle labels: label 1 is the first cycle after the edge that samples start.
// -----------------------------------------------------------------------------
module tb_barrido_tabla_verdad;

  logic       clk;
  logic       rst;
  logic       start;
  int         fsel;
  logic [7:0] tbl;
  logic       f1_q;
  bit         sel;
  int         n_cmp;
  int         n_err;

  barrido_tabla_verdad_if bus0 ();
  barrido_tabla_verdad_if bus1 ();

  assign bus0.start = start;
  assign bus1.start = start;
  assign bus0.F = (fsel == 0) ? (bus0.A & bus0.B & bus0.C) :
                  (fsel == 1) ? (bus0.A | bus0.B) :
                                tbl[{bus0.A, bus0.B, bus0.C}];

  always @(posedge clk) f1_q <= bus1.A ^ bus1.B ^ bus1.C;
  assign bus1.F = f1_q;

  barrido_tabla_verdad #(.SETTLE(2), .EXPECTED(8'h80)) dut0 (
    .clk (clk), .rst (rst), .bus (bus0));
  barrido_tabla_verdad #(.SETTLE(1), .EXPECTED(8'h96)) dut1 (
    .clk (clk), .rst (rst), .bus (bus1));

  logic       o_busy, o_done, o_match;
  logic [2:0] o_vec, o_fail;
  logic [7:0] o_tabla;
  assign o_busy  = sel ? bus1.busy  : bus0.busy;
  assign o_done  = sel ? bus1.done  : bus0.done;
  assign o_match = sel ? bus1.match : bus0.match;
  assign o_vec   = sel ? {bus1.A, bus1.B, bus1.C} : {bus0.A, bus0.B, bus0.C};
  assign o_fail  = sel ? bus1.fail_idx : bus0.fail_idx;
  assign o_tabla = sel ? bus1.tabla : bus0.tabla;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [2:0] ref_fail(input logic [7:0] got, input logic [7:0] want);
    for (int i = 0; i < 8; i++) if (got[i] != want[i]) return 3'(i);
    return 3'd0;
  endfunction

  function automatic logic [7:0] parity_table();
    logic [7:0] t;
    for (int i = 0; i < 8; i++) t[i] = (($countones(i) % 2) == 1);
    return t;
  endfunction

  // One sweep on the selected DUT; stop_at > 0 returns at that label.
  task automatic sweep(input int s, input logic [7:0] exp_tab, input logic [7:0] exp_par,
                       input bit hold, input int stop_at, output logic [7:0] got);
    int         last;
    logic [2:0] v;
    logic [7:0] mask;
    last = 1 + 8 * (s + 1);
    got  = 8'h00;
    start = 1'b1;
    tick();
    if (!hold) start = 1'b0;
    for (int label = 1; label <= last; label++) begin
      if (label == stop_at) return;
      if (label < last) begin
        v = 3'((label - 1) / (s + 1));
        mask = 8'h00;
        for (int j = 0; j < 8; j++) if (j < int'(v)) mask[j] = 1'b1;
        n_cmp++;
        if (o_busy !== 1'b1 || o_done !== 1'b0 || o_vec !== v || o_tabla !== (exp_tab & mask)) begin
          n_err++;
          $display("FAIL sweep_cycle label=%0d: got busy=%b done=%b vec=%0d tabla=%h, need busy=1 done=0 vec=%0d tabla=%h",
                   label, o_busy, o_done, o_vec, o_tabla, v, exp_tab & mask);
        end
        tick();
      end else begin
        n_cmp++;
        if (o_busy !== 1'b0 || o_done !== 1'b1 || o_vec !== 3'd0 || o_tabla !== exp_tab ||
            o_match !== (exp_tab == exp_par) || o_fail !== ref_fail(exp_tab, exp_par)) begin
          n_err++;
          $display("FAIL sweep_done label=%0d: got busy=%b done=%b vec=%0d tabla=%h match=%b fail_idx=%0d, need 0 1 0 %h %b %0d",
                   label, o_busy, o_done, o_vec, o_tabla, o_match, o_fail,
                   exp_tab, (exp_tab == exp_par), ref_fail(exp_tab, exp_par));
        end
        got = o_tabla;
      end
    end
    if (hold) start = 1'b0;
  endtask

  task automatic test_reset();
    sel = 1'b0;
    rst = 1'b1;
    start = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    for (int k = 0; k < 2; k++) begin
      n_cmp++;
      if (o_busy !== 1'b0 || o_done !== 1'b0 || o_vec !== 3'd0 || o_tabla !== 8'h00) begin
        n_err++;
        $display("FAIL reset_idle k=%0d: got busy=%b done=%b vec=%0d tabla=%h, need 0 0 0 00",
                 k, o_busy, o_done, o_vec, o_tabla);
      end
      tick();
    end
    // Reset wins over a simultaneous start.
    rst = 1'b1;
    start = 1'b1;
    tick();
    rst = 1'b0;
    start = 1'b0;
    n_cmp++;
    if (o_busy !== 1'b0 || o_done !== 1'b0) begin
      n_err++;
      $display("FAIL reset_with_start: got busy=%b done=%b, need 0 0", o_busy, o_done);
    end
  endtask

  task automatic test_and();
    logic [7:0] r;
    sel = 1'b0;
    fsel = 0;
    sweep(2, 8'h80, 8'h80, 1'b0, 0, r);
  endtask

  task automatic test_wrong_function();
    logic [7:0] r;
    sel = 1'b0;
    fsel = 1;
    sweep(2, 8'hFC, 8'h80, 1'b0, 0, r);
  endtask

  task automatic test_random_tables();
    logic [7:0] r;
    sel = 1'b0;
    fsel = 2;
    for (int n = 0; n < 4; n++) begin
      tbl = 8'($urandom);
      sweep(2, tbl, 8'h80, 1'b0, 0, r);
    end
  endtask

  task automatic test_held_start();
    logic [7:0] r1, r2;
    sel = 1'b0;
    fsel = 2;
    tbl = 8'($urandom);
    sweep(2, tbl, 8'h80, 1'b1, 0, r1);
    tick();
    n_cmp++;
    if (o_done !== 1'b1 || o_busy !== 1'b0) begin
      n_err++;
      $display("FAIL held_start_single: got done=%b busy=%b, need 1 0", o_done, o_busy);
    end
    sweep(2, tbl, 8'h80, 1'b0, 0, r2);
    n_cmp++;
    if (r2 !== r1 || r2 !== tbl) begin
      n_err++;
      $display("FAIL restart_same: got first=%h second=%h, need %h", r1, r2, tbl);
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] r;
    sel = 1'b0;
    fsel = 1;
    sweep(2, 8'hFC, 8'h80, 1'b0, 1 + 4 * 3 + 2, r);
    n_cmp++;
    if (o_busy !== 1'b1 || o_vec !== 3'd4 || o_tabla !== 8'h0C) begin
      n_err++;
      $display("FAIL mid_sample4: got busy=%b vec=%0d tabla=%h, need 1 4 0c", o_busy, o_vec, o_tabla);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int k = 0; k < 2; k++) begin
      n_cmp++;
      if (o_busy !== 1'b0 || o_done !== 1'b0 || o_vec !== 3'd0 || o_tabla !== 8'h00) begin
        n_err++;
        $display("FAIL mid_reset k=%0d: got busy=%b done=%b vec=%0d tabla=%h, need 0 0 0 00",
                 k, o_busy, o_done, o_vec, o_tabla);
      end
      tick();
    end
    sweep(2, 8'hFC, 8'h80, 1'b0, 0, r);
  endtask

  task automatic test_settle1();
    logic [7:0] r;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    sel = 1'b1;
    sweep(1, parity_table(), 8'h96, 1'b0, 0, r);
    sel = 1'b0;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    fsel  = 0;
    tbl   = 8'h00;
    sel   = 1'b0;
    rst   = 1'b1;
    start = 1'b0;
    test_reset();
    test_and();
    test_wrong_function();
    test_random_tables();
    test_held_start();
    test_reset_mid();
    test_settle1();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
